// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the systolic array controller: FSM state encoding
// and default array geometry.
package tpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int DEF_N        = 2;
  localparam int DEF_MAX_ROWS = 16;

endpackage

// File: rtl/skew_window.sv
// Skew window for one lane or column: enabled while 0 <= s - offset < r,
// and the in-window index is presented as the row address.
module skew_window #(
  parameter int RW = 5,
  parameter int SW = 6
) (
  input  logic [SW-1:0] s,
  input  logic [SW-1:0] offset,
  input  logic [RW-1:0] r,
  output logic          en,
  output logic [RW-1:0] addr
);

  logic signed [SW:0] diff;

  always_comb begin
    diff = $signed({1'b0, s}) - $signed({1'b0, offset});
    en   = !diff[SW] && (diff[SW-1:0] < SW'(r));
    addr = en ? diff[RW-1:0] : '0;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Control sequencer for an N x N weight-stationary systolic array: loads
// weight rows, then streams skewed input rows and captures skewed results.
module systolic_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_ROWS = DEF_MAX_ROWS,
  localparam int RW      = $clog2(MAX_ROWS + 1),
  localparam int WRW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RW-1:0]     num_rows,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      load_weight,
  output logic [WRW-1:0]    w_row,
  output logic              valid,
  output logic [N-1:0]      lane_en,
  output logic [N*RW-1:0]   a_addr,
  output logic [N-1:0]      out_wr_en,
  output logic [N*RW-1:0]   out_addr
);

  // The step counter doubles as the weight-row index during LOAD_W and must
  // reach R+2N-2 during COMPUTE.
  localparam int SW = $clog2(MAX_ROWS + 2 * N);

  state_e            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     r_q, r_d;
  logic [SW-1:0]     last_s;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [N-1:0]      load_weight_q, load_weight_d;
  logic [WRW-1:0]    w_row_q, w_row_d;
  logic [N-1:0]      lane_en_q, lane_en_d;
  logic [N*RW-1:0]   a_addr_q, a_addr_d;
  logic [N-1:0]      out_wr_en_q, out_wr_en_d;
  logic [N*RW-1:0]   out_addr_q, out_addr_d;

  logic [N-1:0]      lane_en_w;
  logic [RW-1:0]     lane_addr_w [N];
  logic [N-1:0]      col_en_w;
  logic [RW-1:0]     col_addr_w [N];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    last_s  = SW'(r_q) + SW'(2 * N - 2);
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = (num_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : num_rows;
          cnt_d   = '0;
          state_d = (num_rows == '0) ? DONE : LOAD_W;
        end
      end
      LOAD_W: begin
        if (cnt_q == SW'(N - 1)) begin
          cnt_d   = '0;
          state_d = COMPUTE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        if (cnt_q == last_s) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        r_d     = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        r_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Windows evaluate the next step so the registered outputs line up with
  // the state they describe.
  for (genvar i = 0; i < N; i++) begin : g_win
    skew_window #(.RW(RW), .SW(SW)) u_lane (
      .s      (cnt_d),
      .offset (SW'(i)),
      .r      (r_d),
      .en     (lane_en_w[i]),
      .addr   (lane_addr_w[i])
    );
    skew_window #(.RW(RW), .SW(SW)) u_col (
      .s      (cnt_d),
      .offset (SW'(N + i)),
      .r      (r_d),
      .en     (col_en_w[i]),
      .addr   (col_addr_w[i])
    );
  end

  always_comb begin
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    valid_d       = (state_d == COMPUTE);
    load_weight_d = (state_d == LOAD_W) ? (N'(1) << cnt_d) : '0;
    w_row_d       = (state_d == LOAD_W) ? cnt_d[WRW-1:0] : '0;
    lane_en_d     = '0;
    a_addr_d      = '0;
    out_wr_en_d   = '0;
    out_addr_d    = '0;
    for (int i = 0; i < N; i++) begin
      lane_en_d[i]   = valid_d & lane_en_w[i];
      out_wr_en_d[i] = valid_d & col_en_w[i];
      if (lane_en_d[i])   a_addr_d[i*RW +: RW]   = lane_addr_w[i];
      if (out_wr_en_d[i]) out_addr_d[i*RW +: RW] = col_addr_w[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      r_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      valid_q       <= 1'b0;
      load_weight_q <= '0;
      w_row_q       <= '0;
      lane_en_q     <= '0;
      a_addr_q      <= '0;
      out_wr_en_q   <= '0;
      out_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      r_q           <= r_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      valid_q       <= valid_d;
      load_weight_q <= load_weight_d;
      w_row_q       <= w_row_d;
      lane_en_q     <= lane_en_d;
      a_addr_q      <= a_addr_d;
      out_wr_en_q   <= out_wr_en_d;
      out_addr_q    <= out_addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign valid       = valid_q;
  assign load_weight = load_weight_q;
  assign w_row       = w_row_q;
  assign lane_en     = lane_en_q;
  assign a_addr      = a_addr_q;
  assign out_wr_en   = out_wr_en_q;
  assign out_addr    = out_addr_q;

endmodule
